// File: rtl/sram_array_1r1w.sv
// sram_array_1r1w -- single-clock SRAM array with one write port (segment
// write mask) and one registered read port. After reset the array is swept
// to zero one entry per cycle before any request is accepted.
//
// Optional feature: define SRAM_ARRAY_BYPASS_EN to make a same-address
// read/write collision return the merged (write-first) value. Without it the
// read returns the value stored before the write (read-first).
//
// state  | meaning
// -------+-------------------------------------------------------------
// INIT   | clearing entry init_cnt each cycle; requests are dropped
// READY  | array cleared; reads and masked writes accepted
module sram_array_1r1w #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 16,
   parameter int MASK_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  W0_en,
   input  logic [ADDR_WIDTH-1:0] W0_addr,
   input  logic [DATA_WIDTH-1:0] W0_data,
   input  logic [MASK_WIDTH-1:0] W0_mask,
   input  logic                  R0_en,
   input  logic [ADDR_WIDTH-1:0] R0_addr,
   output logic [DATA_WIDTH-1:0] R0_data,
   output logic                  R0_valid,
   output logic                  init_done
);

   localparam int DEPTH     = 1 << ADDR_WIDTH;
   localparam int MASK_SAFE = (MASK_WIDTH < 1) ? 1 : MASK_WIDTH;
   localparam int SEG       = DATA_WIDTH / MASK_SAFE;

   // The mask must split the data word into equal whole segments.
   generate
      if (MASK_WIDTH < 1 || (DATA_WIDTH % MASK_SAFE) != 0) begin : g_bad_cfg
         $error("sram_array_1r1w: DATA_WIDTH must be a multiple of MASK_WIDTH >= 1");
      end
   endgenerate

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   init_cnt;
   logic                    is_ready;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic [DATA_WIDTH-1:0]   mask_bits;
   logic                    wr_en;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [DATA_WIDTH-1:0]   wr_bits;
   logic [DATA_WIDTH-1:0]   rd_word;

   assign is_ready = (state == ST_READY);

   // Sequencer: sweep every entry once, then hand the array to the ports.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_INIT;
         init_cnt  <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               if (&init_cnt) begin
                  state     <= ST_READY;
                  init_done <= 1'b1;
                  init_cnt  <= '0;
               end else begin
                  init_cnt  <= init_cnt + ADDR_WIDTH'(1);
               end
            end
            ST_READY: begin
               init_done <= 1'b1;
            end
            default: begin
               state     <= ST_INIT;
               init_cnt  <= '0;
               init_done <= 1'b0;
            end
         endcase
      end
   end

   // Expand the per-segment write mask to a per-bit enable.
   always_comb begin
      mask_bits = '0;
      for (int k = 0; k < MASK_SAFE; k++) begin
         mask_bits[k*SEG +: SEG] = {SEG{W0_mask[k]}};
      end
   end

   // Write port source: the clearing sweep owns the array during INIT.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = W0_addr;
      wr_data = W0_data;
      wr_bits = mask_bits;
      if (!is_ready) begin
         wr_en   = 1'b1;
         wr_addr = init_cnt;
         wr_data = '0;
         wr_bits = '1;
      end else begin
         wr_en   = W0_en;
      end
   end

   // Storage: no reset; only bits enabled by the mask are replaced.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= (mem[wr_addr] & ~wr_bits) | (wr_data & wr_bits);
      end
   end

   // Read value seen by the output register, with optional write-first merge.
   always_comb begin
      rd_word = mem[R0_addr];
`ifdef SRAM_ARRAY_BYPASS_EN
      if (W0_en && (W0_addr == R0_addr)) begin
         rd_word = (rd_word & ~mask_bits) | (W0_data & mask_bits);
      end
`endif
   end

   // Registered read port: data only changes on an accepted read.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         R0_data  <= '0;
         R0_valid <= 1'b0;
      end else begin
         R0_valid <= is_ready && R0_en;
         if (is_ready && R0_en) begin
            R0_data <= rd_word;
         end
      end
   end

endmodule

// File: tb/tb_sram_array_1r1w.sv
// Self-checking bench for sram_array_1r1w (default parameters). Directed
// scenarios plus a randomized stream are checked against an array model.
module tb_sram_array_1r1w;

   logic        clock;
   logic        reset_n;
   logic        W0_en;
   logic [8:0]  W0_addr;
   logic [15:0] W0_data;
   logic [7:0]  W0_mask;
   logic        R0_en;
   logic [8:0]  R0_addr;
   logic [15:0] R0_data;
   logic        R0_valid;
   logic        init_done;

   int tests;
   int fails;

   logic [15:0] mdl [512];
   int          init_left;
   logic [15:0] exp_data;
   logic        exp_valid;
   logic        exp_done;
   bit          bypass;

   sram_array_1r1w dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .W0_en     (W0_en),
      .W0_addr   (W0_addr),
      .W0_data   (W0_data),
      .W0_mask   (W0_mask),
      .R0_en     (R0_en),
      .R0_addr   (R0_addr),
      .R0_data   (R0_data),
      .R0_valid  (R0_valid),
      .init_done (init_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [15:0] merge(input logic [15:0] old_v,
                                         input logic [15:0] new_v,
                                         input logic [7:0]  m);
      logic [15:0] r;
      r = old_v;
      for (int k = 0; k < 8; k++) begin
         if (m[k]) begin
            r[2*k]   = new_v[2*k];
            r[2*k+1] = new_v[2*k+1];
         end
      end
      return r;
   endfunction

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   // One clock cycle: drive, advance the model, sample #1 after the edge.
   task automatic cyc(input bit we, input logic [8:0] wa, input logic [15:0] wd,
                      input logic [7:0] wm, input bit re, input logic [8:0] ra,
                      input string tag);
      bit ready;
      W0_en = we; W0_addr = wa; W0_data = wd; W0_mask = wm;
      R0_en = re; R0_addr = ra;
      ready = (init_left == 0);
      exp_valid = 1'b0;
      if (ready && re) begin
         exp_valid = 1'b1;
         if (bypass && we && wa == ra) exp_data = merge(mdl[ra], wd, wm);
         else                          exp_data = mdl[ra];
      end
      if (ready && we) mdl[wa] = merge(mdl[wa], wd, wm);
      if (!ready) init_left--;
      exp_done = (init_left == 0);
      @(posedge clock);
      #1;
      chk1({tag, ".valid"}, R0_valid, exp_valid);
      chk16({tag, ".data"}, R0_data, exp_data);
      chk1({tag, ".done"}, init_done, exp_done);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      W0_en = 1'b0; R0_en = 1'b0;
      init_left = 512;
      exp_data = '0; exp_valid = 1'b0; exp_done = 1'b0;
      for (int i = 0; i < 512; i++) mdl[i] = '0;
      #2;
      chk16("rst.data", R0_data, 16'h0000);
      chk1("rst.valid", R0_valid, 1'b0);
      chk1("rst.done", init_done, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      int low_cycles;
      tests = 0; fails = 0;
`ifdef SRAM_ARRAY_BYPASS_EN
      bypass = 1'b1;
`else
      bypass = 1'b0;
`endif
      W0_en = 0; W0_addr = '0; W0_data = '0; W0_mask = '0;
      R0_en = 0; R0_addr = '0;
      reset_n = 1'b0;
      #3;
      do_reset();

      // INIT sweep; a write+read is issued at cycle 100 and must be dropped.
      low_cycles = 0;
      for (int i = 0; i < 512; i++) begin
         if (i == 100) cyc(1, 9'h007, 16'hBEEF, 8'hFF, 1, 9'h007, "init_req");
         else          cyc(0, '0, '0, '0, 0, '0, "init");
         if (!init_done) low_cycles++;
      end
      chk16("init_low_cycles", 16'(low_cycles), 16'd511);

      cyc(1'b0, '0, '0, '0, 1'b1, 9'h1FF, "rd_1ff");
      chk16("rd_1ff.lit", R0_data, 16'h0000);
      chk1("rd_1ff.vlit", R0_valid, 1'b1);
      cyc(1'b0, '0, '0, '0, 1'b1, 9'h007, "rd_007");
      chk16("init_drop.lit", R0_data, 16'h0000);

      // Segment masking.
      cyc(1, 9'h005, 16'hABCD, 8'hFF, 0, '0, "w005a");
      cyc(1, 9'h005, 16'h1234, 8'h0F, 0, '0, "w005b");
      cyc(0, '0, '0, '0, 1, 9'h005, "r005");
      chk16("mask.lit", R0_data, 16'hAB34);

      // Same-address collision.
      cyc(1, 9'h010, 16'h5555, 8'hFF, 0, '0, "w010");
      cyc(1, 9'h010, 16'hFFFF, 8'hF0, 1, 9'h010, "coll");
      chk16("coll.lit", R0_data, bypass ? 16'hFF55 : 16'h5555);
      cyc(0, '0, '0, '0, 1, 9'h010, "coll_after");
      chk16("coll_after.lit", R0_data, 16'hFF55);

      // Read data holds when no read is issued.
      cyc(1, 9'h020, 16'h0F0F, 8'hFF, 0, '0, "w020");
      cyc(0, '0, '0, '0, 1, 9'h020, "r020");
      cyc(1, 9'h020, 16'hFFFF, 8'hFF, 0, '0, "hold");
      chk16("hold.lit", R0_data, 16'h0F0F);
      chk1("hold.vlit", R0_valid, 1'b0);

      // Different-address write and read together, then back-to-back reads.
      cyc(1, 9'h030, 16'h1357, 8'hFF, 1, 9'h005, "diff");
      chk16("diff.lit", R0_data, 16'hAB34);
      for (int i = 0; i < 4; i++) cyc(0, '0, '0, '0, 1, 9'(32'h030 - 32'(i) * 16), "b2b");

      // Randomized stream over a small window to provoke collisions.
      for (int i = 0; i < 1500; i++) begin
         cyc(1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), 16'($urandom),
             8'($urandom), 1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), "rand");
      end

      // Reset in the middle of traffic clears everything.
      cyc(1, 9'h003, 16'h7777, 8'hFF, 0, '0, "w003");
      cyc(0, '0, '0, '0, 1, 9'h003, "r003");
      chk16("w003.lit", R0_data, 16'h7777);
      cyc(1, 9'h004, 16'h1111, 8'hFF, 1, 9'h003, "pre_rst");
      do_reset();
      for (int i = 0; i < 512; i++) cyc(0, '0, '0, '0, 0, '0, "reinit");
      cyc(0, '0, '0, '0, 1, 9'h003, "r003_after");
      chk16("rst_clear.lit", R0_data, 16'h0000);
      chk1("rst_clear.vlit", R0_valid, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
